// File: rtl/ads1672_sample_averager.sv
// Requests ADS1672 conversions, averages 2^LOG2_AVG signed samples and offers
// the mean on a valid/ready port, with sticky overrun and timeout flags.
module ads1672_sample_averager #(
  parameter int DATA_WIDTH     = 24,
  parameter int LOG2_AVG       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  measure,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  avg_valid,
  input  logic                  avg_ready,
  output logic [DATA_WIDTH-1:0] avg_data,
  output logic                  overrun,
  output logic                  timeout,
  input  logic                  clear_flags,
  output logic                  busy
);

  localparam int ACC_W = DATA_WIDTH + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_SAMPLE} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic [CNT_W-1:0]        cnt;
  logic [TO_W-1:0]         to_cnt;
  logic                    batch_end, to_hit, take;
  logic [DATA_WIDTH-1:0]   avg_res;

  // acc is wide enough for a full batch, so the sum never wraps
  assign acc_sum = acc + ACC_W'($signed(sample_data));
  assign avg_res = DATA_WIDTH'(acc_sum >>> LOG2_AVG);
  assign take    = (state == WAIT_SAMPLE) && sample_valid;
  assign measure = (state == REQ);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    batch_end = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE: if (enable) state_nxt = REQ;
      REQ:  state_nxt = WAIT_SAMPLE;
      WAIT_SAMPLE: begin
        if (sample_valid) begin
          if (cnt == CNT_LAST) begin
            batch_end = 1'b1;
            state_nxt = enable ? REQ : IDLE;
          end else begin
            state_nxt = REQ;
          end
        end else if (to_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == REQ)
        to_cnt <= '0;
      else if ((state == WAIT_SAMPLE) && !sample_valid)
        to_cnt <= to_cnt + TO_W'(1);
      // a timed-out partial batch is dropped, not carried into the next one
      if (batch_end || to_hit) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_valid <= 1'b0;
      avg_data  <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (batch_end) begin
        avg_data  <= avg_res;
        avg_valid <= 1'b1;
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end
      // set beats clear when both land on the same edge
      if (batch_end && avg_valid && !avg_ready) overrun <= 1'b1;
      else if (clear_flags)                     overrun <= 1'b0;
      if (to_hit)           timeout <= 1'b1;
      else if (clear_flags) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ads1672_sample_averager.sv
// Directed + randomized bench for ads1672_sample_averager (LOG2_AVG=2, TIMEOUT_CYCLES=8).
module tb_ads1672_sample_averager;
  localparam int DW = 24;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          measure;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          avg_valid;
  logic          avg_ready = 1'b0;
  logic [DW-1:0] avg_data;
  logic          overrun, timeout;
  logic          clear_flags = 1'b0;
  logic          busy;

  int            errors = 0;
  int            checks = 0;
  int            mcount = 0;
  int            mc0;
  int            k;
  logic [DW-1:0] smp [4];

  ads1672_sample_averager #(.DATA_WIDTH(DW), .LOG2_AVG(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .measure(measure),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .avg_valid(avg_valid), .avg_ready(avg_ready), .avg_data(avg_data),
    .overrun(overrun), .timeout(timeout), .clear_flags(clear_flags), .busy(busy));

  always #5 clk = ~clk;

  // counts REQ cycles; read on posedge, before the DUT updates state
  always @(posedge clk) if (measure === 1'b1) mcount++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mean of four samples, floor toward -inf, from plain integer arithmetic
  function automatic logic [DW-1:0] ref_avg();
    longint s = 0;
    longint q;
    for (int i = 0; i < 4; i++) s += $signed(smp[i]);
    q = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    return q[DW-1:0];
  endfunction

  task automatic wait_meas();
    int n = 0;
    while (measure !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("measure_wait", 32'(measure), 1);
  endtask

  task automatic send_one(input logic [DW-1:0] d, input int gap, input bit rdy);
    wait_meas();
    @(negedge clk);
    repeat (gap) @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    if (rdy) avg_ready = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic run_batch(input int drop_at, input bit rdy_last, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      if (i == drop_at) enable = 1'b0;
      send_one(smp[i], rnd ? int'($urandom_range(0, 5)) : 0, rdy_last && (i == 3));
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_valid"}, 32'(avg_valid), 1);
    chk({tag, "_data"}, 32'(avg_data), 32'(ref_avg()));
    chk({tag, "_next_measure"}, 32'(measure), 32'(enable));
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_measure", 32'(measure), 0);
    chk("rst_avg_valid", 32'(avg_valid), 0);
    chk("rst_avg_data", 32'(avg_data), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic average, exactly four requests before the result
    enable = 1'b1; avg_ready = 1'b1;
    smp = '{24'd100, 24'd200, 24'd300, 24'd400};
    mc0 = mcount;
    run_batch(3, 0, 0);
    chk_result("basic");
    chk("basic_data_250", 32'(avg_data), 250);
    chk("basic_meas_count", 32'(mcount - mc0), 4);
    @(negedge clk);
    chk("basic_one_cycle", 32'(avg_valid), 0);
    chk("basic_idle", 32'(busy), 0);

    // negative rounding and extremes, back to back
    enable = 1'b1;
    smp = '{24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC};
    run_batch(-1, 0, 1);
    chk_result("neg");
    chk("neg_data_m3", 32'(avg_data), 32'h00FFFFFD);
    smp = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
    run_batch(-1, 0, 1);
    chk_result("max");
    smp = '{24'h800000, 24'h800000, 24'h800000, 24'h800000};
    run_batch(-1, 0, 1);
    chk_result("min");

    // random batches
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 4; i++)
        smp[i] = ($urandom_range(0, 4) == 0) ? 24'h800000 : 24'($urandom);
      run_batch((b == 5) ? 3 : -1, 0, 1);
      chk_result("rand");
    end
    @(negedge clk);
    chk("overrun_none", 32'(overrun), 0);

    // backpressure and overrun
    enable = 1'b1; avg_ready = 1'b0;
    smp = '{24'd10, 24'd10, 24'd10, 24'd10};
    run_batch(-1, 0, 1);
    chk_result("bp1");
    smp = '{24'd20, 24'd20, 24'd20, 24'd20};
    run_batch(3, 0, 1);
    chk_result("bp2");
    chk("bp2_overrun", 32'(overrun), 1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("bp_cleared", 32'(overrun), 0);
    chk("bp_held_valid", 32'(avg_valid), 1);
    chk("bp_held_data", 32'(avg_data), 20);
    enable = 1'b1;
    smp = '{24'd30, 24'd30, 24'd30, 24'd30};
    run_batch(3, 1, 1);
    chk_result("bp3");
    chk("bp3_no_overrun", 32'(overrun), 0);
    @(negedge clk);
    chk("bp3_accepted", 32'(avg_valid), 0);

    // enable dropped after the second sample still completes the batch
    enable = 1'b1;
    for (int i = 0; i < 4; i++) smp[i] = 24'($urandom);
    run_batch(2, 0, 1);
    chk_result("drop");
    mc0 = mcount;
    repeat (12) @(negedge clk);
    chk("drop_no_measure", 32'(mcount - mc0), 0);
    chk("drop_idle", 32'(busy), 0);

    // partial batch then timeout: TO wait cycles after the REQ cycle
    avg_ready = 1'b0;
    enable = 1'b1;
    send_one(24'd1000, 0, 0);
    send_one(24'd1000, 0, 0);
    enable = 1'b0;
    wait_meas();
    k = 0;
    while (timeout !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
      if (k == TO) chk("to_still_busy", 32'(busy), 1);
    end
    chk("to_latency", 32'(k), TO + 1);
    chk("to_flag", 32'(timeout), 1);
    chk("to_busy_low", 32'(busy), 0);
    // stray sample in IDLE must be ignored
    sample_valid = 1'b1; sample_data = 24'h100000;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_valid", 32'(avg_valid), 0);
    chk("stray_timeout_kept", 32'(timeout), 1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("to_cleared", 32'(timeout), 0);
    enable = 1'b1;
    smp = '{24'd4, 24'd8, 24'd12, 24'd16};
    run_batch(3, 0, 1);
    chk_result("after_to");
    chk("after_to_10", 32'(avg_data), 10);

    // async reset while waiting for a sample
    enable = 1'b1;
    send_one(24'd5000, 0, 0);
    wait_meas();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_measure", 32'(measure), 0);
    chk("arst_avg_valid", 32'(avg_valid), 0);
    chk("arst_avg_data", 32'(avg_data), 0);
    chk("arst_overrun", 32'(overrun), 0);
    chk("arst_timeout", 32'(timeout), 0);
    chk("arst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    avg_ready = 1'b1;
    for (int i = 0; i < 4; i++) smp[i] = 24'($urandom);
    run_batch(3, 0, 1);
    chk_result("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ads1672_sample_averager.md
# ads1672_sample_averager

Downstream consumer of the ADS1672-EVM controller. It requests conversions from the controller through `measure` and accepts each returned 24-bit two's-complement sample. It sums 2^LOG2_AVG samples and presents their arithmetic-shifted mean on a valid/ready output port to the processing/streaming logic. It also reports overrun and conversion-timeout conditions as sticky flags.

## Interface
- `DATA_WIDTH`, 24: sample and result width, two's complement.
- `LOG2_AVG`, 4: log2 of samples per result (N = 2^LOG2_AVG); 0 means passthrough.
- `TIMEOUT_CYCLES`, 65535: maximum cycles in WAIT_SAMPLE before timeout; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  level; requests continuous acquisition.
- `measure`  out  1  one-cycle conversion-request pulse to the ADC controller.
- `sample_valid`  in  1  one-cycle strobe; `sample_data` is valid this cycle.
- `sample_data`  in  DATA_WIDTH  signed sample from the controller.
- `avg_valid`  out  1  result available.
- `avg_ready`  in  1  consumer accepts the result.
- `avg_data`  out  DATA_WIDTH  signed averaged result.
- `overrun`  out  1  sticky; a result was overwritten before it was accepted.
- `timeout`  out  1  sticky; a sample did not arrive within TIMEOUT_CYCLES.
- `clear_flags`  in  1  one-cycle pulse that clears `overrun` and `timeout`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, REQ and WAIT_SAMPLE. `measure` = (state==REQ). `busy` = (state!=IDLE).
- **IDLE:** if `enable`=1, go to REQ. Otherwise stay.
- **REQ:** always lasts one cycle, then go to WAIT_SAMPLE. The timeout counter clears on entry.
- **WAIT_SAMPLE:**
  - On `sample_valid`: acc ← acc + sext(sample_data) and cnt ← cnt+1.
  - If cnt was N−1, this is the batch end: load the result, clear acc and cnt, then go to REQ if `enable`=1, else IDLE.
  - Any other accepted sample: go to REQ.
  - With no `sample_valid`, the counter increments. When the counter reaches TIMEOUT_CYCLES: set `timeout`, discard acc and cnt, go to IDLE.
- `enable` is examined only in IDLE and at batch end. Deasserting it mid-batch still completes the batch.
- `sample_valid` outside WAIT_SAMPLE is ignored, with no state or flag change.
- **Arithmetic:**
  - acc is signed, DATA_WIDTH+LOG2_AVG bits, so it cannot overflow.
  - Result = (acc + sext(final sample)) >>> LOG2_AVG. This is an arithmetic shift, rounding toward −∞.
  - The result always fits in DATA_WIDTH bits.
- **Output register:**
  - `avg_data`/`avg_valid` are held until the edge where `avg_valid`&&`avg_ready`, which clears `avg_valid`.
  - New result while `avg_valid`=1 and `avg_ready`=1 on the same edge: load new data, `avg_valid` stays 1, no overrun.
  - New result while `avg_valid`=1 and `avg_ready`=0: overwrite data and set `overrun`.
- **Flags:** `clear_flags` clears both flags. If a set event occurs on the same edge, set wins.

## Timing
- **Reset values (asserted asynchronously):** `measure`=0, `avg_valid`=0, `avg_data`=0, `overrun`=0, `timeout`=0, `busy`=0. Internally state=IDLE, acc=0, cnt=0, timeout counter=0.
- Reset release mid-batch means the partial batch is lost. There is no pending request after reset.
- **Request latency:** `enable` high in IDLE at edge k gives `measure` high for exactly the cycle after edge k.
- **Result latency:** `avg_valid` is high in the cycle immediately following the cycle carrying the Nth `sample_valid`.
- **Back-to-back batches:** the next `measure` is coincident with the first cycle of `avg_valid`.
- **Timeout:** `timeout` rises TIMEOUT_CYCLES cycles after the REQ cycle when no sample arrives. `busy` falls on the same edge.
- Minimum spacing between `measure` pulses is 2 cycles (REQ, then WAIT_SAMPLE for at least one cycle).

## Test plan
- **Basic average:** LOG2_AVG=2, enable=1, samples 100, 200, 300, 400, avg_ready=1 → one 1-cycle `avg_valid` with `avg_data`=250. Exactly 4 `measure` pulses precede it, each followed by one sample.
- **Negative rounding and extremes:**
  - samples 0xFFFFFF, 0xFFFFFE, 0xFFFFFD, 0xFFFFFC (−1..−4) → 0xFFFFFD (−3).
  - four of 0x7FFFFF → 0x7FFFFF.
  - four of 0x800000 → 0x800000.
- **Backpressure and overrun:** avg_ready=0 across two batches (10×4, then 20×4) → `avg_data`=20, `overrun`=1. A `clear_flags` pulse → `overrun`=0. Repeat with avg_ready=1 on the reload edge → `overrun` stays 0.
- **Timeout:** TIMEOUT_CYCLES=8, never drive `sample_valid` → `timeout`=1 exactly 8 cycles after the `measure` cycle, `busy`=0. The next batch starts from acc=0. A stray `sample_valid` in IDLE has no effect.
- **Enable drop mid-batch:** deassert enable after sample 2 of 4 → the batch completes with the correct average, then IDLE, with no further `measure`.
- **Async reset mid-batch:** pulse rst_n low between two clock edges during WAIT_SAMPLE → all outputs are 0 immediately. With enable=1 after release, the first result equals the mean of the 4 post-reset samples only.
